// File: rtl/stopwatch_lap.sv
// Lap stopwatch: prescaled 1 s tick driving a min:sec counter (wrap or saturate),
// a start/stop/clear control FSM and a show-ahead lap FIFO.
module stopwatch_lap #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int OUT_W     = 9,
    parameter int MAX_MIN   = 59,
    parameter int WRAP      = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_stop,
    input  logic                         clear,
    input  logic                         lap,
    input  logic                         lap_rd,
    output logic [OUT_W-1:0]             sec,
    output logic [OUT_W-1:0]             min,
    output logic                         running,
    output logic                         overflow,
    output logic [OUT_W-1:0]             lap_sec,
    output logic [OUT_W-1:0]             lap_min,
    output logic                         lap_valid,
    output logic                         lap_full,
    output logic [$clog2(LAP_DEPTH):0]   lap_count
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 2 * OUT_W;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

    state_t            state, state_next;
    logic [PW-1:0]     presc;
    logic              tick;
    logic              at_max;
    logic              saturate;

    logic [TW-1:0]     mem [LAP_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic [TW-1:0]     head;

    // One-second advance of {min, sec}; at the top value either rolls over or holds.
    function automatic logic [TW-1:0] advance(input logic [OUT_W-1:0] s,
                                              input logic [OUT_W-1:0] m);
        if (s != OUT_W'(59))
            return {m, s + OUT_W'(1)};
        if (m != OUT_W'(MAX_MIN))
            return {m + OUT_W'(1), OUT_W'(0)};
        if (WRAP != 0)
            return '0;
        return {m, s};
    endfunction

    assign tick     = (state == RUN) && (presc == PW'(TICK_DIV - 1));
    assign at_max   = (sec == OUT_W'(59)) && (min == OUT_W'(MAX_MIN));
    assign saturate = tick && at_max && (WRAP == 0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        running    = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_stop) state_next = RUN;
                RUN:     if (saturate) state_next = SAT;
                         else if (start_stop) state_next = PAUSE;
                PAUSE:   if (start_stop) state_next = RUN;
                SAT:     state_next = SAT;
                default: state_next = IDLE;
            endcase
        end
        running = (state == RUN);
    end

    // Prescaler only advances in RUN, so a pause keeps the fractional second.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc    <= '0;
            sec      <= '0;
            min      <= '0;
            overflow <= 1'b0;
        end else begin
            if (tick)
                presc <= '0;
            else if (state == RUN)
                presc <= presc + PW'(1);
            else if (state == IDLE)
                presc <= '0;
            if (tick)
                {min, sec} <= advance(sec, min);
            if (saturate)
                overflow <= 1'b1;
        end
    end

    // A pop frees a slot in the same cycle, so lap+lap_rd on a full FIFO still pushes.
    assign pop  = lap_rd && (count != '0);
    assign push = lap && ((count != CW'(LAP_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {min, sec};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign lap_valid = (count != '0);
    assign lap_full  = (count == CW'(LAP_DEPTH));
    assign lap_count = count;
    assign lap_sec   = lap_valid ? head[OUT_W-1:0] : '0;
    assign lap_min   = lap_valid ? head[TW-1:OUT_W] : '0;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: three differently parametrised instances share one
// stimulus stream and are compared every cycle against a total-seconds/array model.
module tb_stopwatch_lap;

    logic clk = 1'b0;
    logic rst = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0, lap_rd = 1'b0;

    logic [8:0] a_sec, a_min, a_lap_sec, a_lap_min;
    logic       a_running, a_overflow, a_lap_valid, a_lap_full;
    logic [2:0] a_lap_count;
    logic [8:0] b_sec, b_min, b_lap_sec, b_lap_min;
    logic       b_running, b_overflow, b_lap_valid, b_lap_full;
    logic [1:0] b_lap_count;
    logic [8:0] c_sec, c_min, c_lap_sec, c_lap_min;
    logic       c_running, c_overflow, c_lap_valid, c_lap_full;
    logic [3:0] c_lap_count;

    int n_tests = 0;
    int n_fail  = 0;

    int m_secs  [3];
    int m_phase [3];
    bit m_run   [3];
    bit m_sat   [3];
    bit m_ovf   [3];
    int m_cnt   [3];
    int m_fifo  [3][16];

    always #5 clk = ~clk;

    stopwatch_lap #(.TICK_DIV(4), .OUT_W(9), .MAX_MIN(59), .WRAP(1), .LAP_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap), .lap_rd(lap_rd),
        .sec(a_sec), .min(a_min), .running(a_running), .overflow(a_overflow),
        .lap_sec(a_lap_sec), .lap_min(a_lap_min), .lap_valid(a_lap_valid),
        .lap_full(a_lap_full), .lap_count(a_lap_count));

    stopwatch_lap #(.TICK_DIV(3), .OUT_W(9), .MAX_MIN(1), .WRAP(1), .LAP_DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap), .lap_rd(lap_rd),
        .sec(b_sec), .min(b_min), .running(b_running), .overflow(b_overflow),
        .lap_sec(b_lap_sec), .lap_min(b_lap_min), .lap_valid(b_lap_valid),
        .lap_full(b_lap_full), .lap_count(b_lap_count));

    stopwatch_lap #(.TICK_DIV(4), .OUT_W(9), .MAX_MIN(1), .WRAP(0), .LAP_DEPTH(8)) u_c (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap), .lap_rd(lap_rd),
        .sec(c_sec), .min(c_min), .running(c_running), .overflow(c_overflow),
        .lap_sec(c_lap_sec), .lap_min(c_lap_min), .lap_valid(c_lap_valid),
        .lap_full(c_lap_full), .lap_count(c_lap_count));

    function automatic int p_div(int i);
        return (i == 1) ? 3 : 4;
    endfunction
    function automatic int p_max(int i);
        return (i == 0) ? 59 : 1;
    endfunction
    function automatic bit p_wrap(int i);
        return (i != 2);
    endfunction
    function automatic int p_depth(int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 8);
    endfunction

    function automatic logic [63:0] pk(int s, int m, int ls, int lm,
                                       bit r, bit o, bit v, bit f, int c);
        return {16'd0, s[8:0], m[8:0], ls[8:0], lm[8:0], r, o, v, f, c[7:0]};
    endfunction

    function automatic logic [63:0] obs(int i);
        if (i == 0)
            return pk(int'(a_sec), int'(a_min), int'(a_lap_sec), int'(a_lap_min),
                      a_running, a_overflow, a_lap_valid, a_lap_full, int'(a_lap_count));
        if (i == 1)
            return pk(int'(b_sec), int'(b_min), int'(b_lap_sec), int'(b_lap_min),
                      b_running, b_overflow, b_lap_valid, b_lap_full, int'(b_lap_count));
        return pk(int'(c_sec), int'(c_min), int'(c_lap_sec), int'(c_lap_min),
                  c_running, c_overflow, c_lap_valid, c_lap_full, int'(c_lap_count));
    endfunction

    function automatic logic [63:0] obs_lap_a();
        return pk(0, 0, int'(a_lap_sec), int'(a_lap_min), 1'b0, 1'b0,
                  a_lap_valid, a_lap_full, int'(a_lap_count));
    endfunction

    function automatic logic [63:0] expect_of(int i);
        int h;
        h = (m_cnt[i] > 0) ? m_fifo[i][0] : 0;
        return pk(m_secs[i] % 60, m_secs[i] / 60, h % 60, h / 60, m_run[i], m_ovf[i],
                  m_cnt[i] > 0, m_cnt[i] == p_depth(i), m_cnt[i]);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: time is a plain count of elapsed seconds, laps an ordered array.
    task automatic model_edge(bit r, bit ss, bit cl, bit lp, bit rd);
        for (int i = 0; i < 3; i++) begin
            int lim;
            int pv;
            bit tk, sat_now, do_pop, do_push;
            if (r || cl) begin
                m_secs[i] = 0; m_phase[i] = 0; m_run[i] = 0;
                m_sat[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
            end else begin
                lim     = (p_max(i) + 1) * 60 - 1;
                pv      = m_secs[i];
                tk      = m_run[i] && (m_phase[i] == p_div(i) - 1);
                sat_now = 0;
                if (m_run[i])
                    m_phase[i] = tk ? 0 : m_phase[i] + 1;
                if (tk) begin
                    if (m_secs[i] < lim) m_secs[i] = m_secs[i] + 1;
                    else if (p_wrap(i)) m_secs[i] = 0;
                    else sat_now = 1;
                end
                if (ss && !m_sat[i])
                    m_run[i] = !m_run[i];
                if (sat_now) begin
                    m_sat[i] = 1; m_run[i] = 0; m_ovf[i] = 1;
                end
                do_pop  = rd && (m_cnt[i] > 0);
                do_push = lp && ((m_cnt[i] < p_depth(i)) || do_pop);
                if (do_pop) begin
                    for (int j = 0; j < 15; j++) m_fifo[i][j] = m_fifo[i][j + 1];
                    m_cnt[i] = m_cnt[i] - 1;
                end
                if (do_push) begin
                    m_fifo[i][m_cnt[i]] = pv;
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    endtask

    task automatic step(bit r, bit ss, bit cl, bit lp, bit rd);
        rst = r; start_stop = ss; clear = cl; lap = lp; lap_rd = rd;
        @(posedge clk);
        model_edge(r, ss, cl, lp, rd);
        #1;
        rst = 0; start_stop = 0; clear = 0; lap = 0; lap_rd = 0;
        check_eq("model_a", obs(0), expect_of(0));
        check_eq("model_b", obs(1), expect_of(1));
        check_eq("model_c", obs(2), expect_of(2));
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        check_eq("reset_a", obs(0), 64'd0);
        check_eq("reset_c", obs(2), 64'd0);

        // 240 cycles at 4 cycles/s is one minute
        step(0, 1, 0, 0, 0);
        idle(240);
        check_eq("run_240", obs(0), pk(0, 1, 0, 0, 1, 0, 0, 0, 0));

        idle(1);
        step(0, 1, 0, 0, 0);
        check_eq("pause_enter", obs(0), pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        idle(50);
        check_eq("pause_hold", obs(0), pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0);
        check_eq("resume", obs(0), pk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        idle(1);
        check_eq("resume_1", obs(0), pk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        idle(1);
        check_eq("resume_2", obs(0), pk(1, 1, 0, 0, 1, 0, 0, 0, 0));

        step(0, 1, 1, 0, 0);
        check_eq("clear_ss", obs(0), 64'd0);

        // laps at 00:01..00:05; the fifth is dropped
        step(0, 1, 0, 0, 0);
        idle(4);
        for (int n = 1; n <= 5; n++) begin
            step(0, 0, 0, 1, 0);
            if (n < 5) idle(3);
        end
        check_eq("lap_full", obs(0), pk(5, 0, 1, 0, 1, 0, 1, 1, 4));
        for (int n = 1; n <= 4; n++) begin
            step(0, 0, 0, 0, 1);
            if (n < 4)
                check_eq("lap_pop", obs_lap_a(), pk(0, 0, n + 1, 0, 0, 0, 1, 0, 4 - n));
            else
                check_eq("lap_empty", obs_lap_a(), 64'd0);
        end

        step(0, 0, 0, 1, 0);
        check_eq("lap_one", obs_lap_a(), pk(0, 0, 6, 0, 0, 0, 1, 0, 1));
        idle(2);
        step(0, 0, 0, 1, 1);
        check_eq("lap_push_pop", obs_lap_a(), pk(0, 0, 7, 0, 0, 0, 1, 0, 1));

        // lap on the cycle that ticks 00:07 -> 00:08
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(31);
        step(0, 0, 0, 1, 0);
        check_eq("lap_on_tick", obs(0), pk(8, 0, 7, 0, 1, 0, 1, 0, 1));

        for (int n = 0; n < 2; n++) begin
            step(0, 0, 0, 1, 0);
            idle(1);
        end
        check_eq("three_laps", obs_lap_a(), pk(0, 0, 7, 0, 0, 0, 1, 0, 3));
        step(1, 0, 0, 0, 0);
        check_eq("rst_mid_a", obs(0), 64'd0);
        check_eq("rst_mid_b", obs(1), 64'd0);
        step(0, 1, 0, 0, 0);
        idle(4);
        step(0, 0, 0, 1, 0);
        check_eq("relap", obs(0), pk(1, 0, 1, 0, 1, 0, 1, 0, 1));

        // wrap (u_b, 3 cycles/s) and saturation (u_c, 4 cycles/s) at MAX_MIN=1
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 480; i++) begin
            idle(1);
            if (i == 357) check_eq("wrap_pre", obs(1), pk(59, 1, 0, 0, 1, 0, 0, 0, 0));
            if (i == 360) check_eq("wrap_post", obs(1), pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
            if (i == 476) check_eq("sat_pre", obs(2), pk(59, 1, 0, 0, 1, 0, 0, 0, 0));
            if (i == 480) check_eq("sat_post", obs(2), pk(59, 1, 0, 0, 0, 1, 0, 0, 0));
        end
        step(0, 1, 0, 0, 0);
        check_eq("sat_ss", obs(2), pk(59, 1, 0, 0, 0, 1, 0, 0, 0));
        idle(8);
        check_eq("sat_hold", obs(2), pk(59, 1, 0, 0, 0, 1, 0, 0, 0));
        step(0, 0, 1, 0, 0);
        check_eq("sat_clear", obs(2), 64'd0);

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 999) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 399) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
